// File: rtl/cnn_layer_accel_weight_seq_engine.sv
// Purpose: programmable weight-address sequencer; walks one of NUM_SEQ loadable address lists onto a valid/ready stream.
// Latency: first address one cycle after start, then one address per cycle while rdy is held high.
// Backpressure: address/last held stable while vld && !rdy; stop aborts without done.
module cnn_layer_accel_weight_seq_engine #(
    parameter int NUM_SEQ    = 4,
    parameter int SEQ_DEPTH  = 8,
    parameter int WHT_ADDR_W = 4,
    parameter int SEL_W      = $clog2(NUM_SEQ),
    parameter int IDX_W      = $clog2(SEQ_DEPTH),
    parameter int LEN_W      = $clog2(SEQ_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [SEL_W-1:0]      cfg_wr_seq,
    input  logic [IDX_W-1:0]      cfg_wr_idx,
    input  logic [WHT_ADDR_W-1:0] cfg_wr_data,
    input  logic                  cfg_len_wr_en,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  start,
    input  logic [SEL_W-1:0]      seq_sel,
    input  logic                  loop_en,
    input  logic                  stop,
    input  logic                  wht_addr_rdy,
    output logic                  wht_addr_vld,
    output logic [WHT_ADDR_W-1:0] wht_addr,
    output logic                  wht_addr_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [SEL_W:0]   NUM_SEQ_V = (SEL_W + 1)'(NUM_SEQ);
    localparam logic [IDX_W:0]   DEPTH_I   = (IDX_W + 1)'(SEQ_DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(SEQ_DEPTH);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    logic [WHT_ADDR_W-1:0] tbl   [NUM_SEQ][SEQ_DEPTH];
    logic [LEN_W-1:0]      len_q [NUM_SEQ];

    state_t                state, state_n;
    logic [SEL_W-1:0]      sel, sel_n;
    logic                  loop_q, loop_n;
    logic [LEN_W-1:0]      idx, idx_n, idx_inc, cur_len;
    logic                  vld_n, last_n, done_n, err_n;
    logic [WHT_ADDR_W-1:0] addr_n;
    logic                  tbl_we, len_we;
    logic                  sel_ok, idx_ok, len_ok;

    assign sel_ok  = ({1'b0, seq_sel} < NUM_SEQ_V);
    assign idx_ok  = ({1'b0, cfg_wr_idx} < DEPTH_I);
    assign len_ok  = (cfg_len != '0) && (cfg_len <= DEPTH_L);
    assign cur_len = len_q[sel];
    assign idx_inc = idx + ONE_L;
    assign busy    = (state == S_RUN);

    // Next-state, next-beat and command-check logic; done outranks a concurrent rejected command.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        loop_n  = loop_q;
        idx_n   = idx;
        vld_n   = wht_addr_vld;
        addr_n  = wht_addr;
        last_n  = wht_addr_last;
        done_n  = 1'b0;
        err_n   = 1'b0;
        tbl_we  = 1'b0;
        len_we  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        state_n = S_RUN;
                        sel_n   = seq_sel;
                        loop_n  = loop_en;
                        idx_n   = '0;
                        vld_n   = 1'b1;
                        addr_n  = tbl[seq_sel][0];
                        last_n  = (len_q[seq_sel] == ONE_L);
                    end
                    if (!sel_ok || cfg_wr_en || cfg_len_wr_en) err_n = 1'b1;
                end else begin
                    tbl_we = cfg_wr_en && idx_ok;
                    if (cfg_len_wr_en) begin
                        if (len_ok) len_we = 1'b1;
                        else        err_n  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (start || cfg_wr_en || cfg_len_wr_en) err_n = 1'b1;
                if (stop) begin
                    state_n = S_IDLE;
                    vld_n   = 1'b0;
                    last_n  = 1'b0;
                end else if (wht_addr_vld && wht_addr_rdy) begin
                    if (wht_addr_last) begin
                        if (loop_q) begin
                            idx_n  = '0;
                            addr_n = tbl[sel][0];
                            last_n = (cur_len == ONE_L);
                        end else begin
                            state_n = S_IDLE;
                            vld_n   = 1'b0;
                            last_n  = 1'b0;
                            done_n  = 1'b1;
                            err_n   = 1'b0;
                        end
                    end else begin
                        idx_n  = idx_inc;
                        addr_n = tbl[sel][idx_inc[IDX_W-1:0]];
                        last_n = (idx_inc == cur_len - ONE_L);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control and output registers; reset aborts any run with no done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            sel           <= '0;
            loop_q        <= 1'b0;
            idx           <= '0;
            wht_addr_vld  <= 1'b0;
            wht_addr      <= '0;
            wht_addr_last <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            state         <= state_n;
            sel           <= sel_n;
            loop_q        <= loop_n;
            idx           <= idx_n;
            wht_addr_vld  <= vld_n;
            wht_addr      <= addr_n;
            wht_addr_last <= last_n;
            done          <= done_n;
            cfg_err       <= err_n;
        end
    end

    // Sequence table and lengths; writable only from IDLE, cleared to zero entries / full length on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SEQ; s++) begin
                len_q[s] <= DEPTH_L;
                for (int i = 0; i < SEQ_DEPTH; i++) tbl[s][i] <= '0;
            end
        end else begin
            if (tbl_we) tbl[cfg_wr_seq][cfg_wr_idx] <= cfg_wr_data;
            if (len_we) len_q[cfg_wr_seq] <= cfg_len;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_engine.sv
// Purpose: randomized and directed bench for the weight-address sequencer against a list-based reference model.
// Latency: expects first address one cycle after start and one address per accepted beat.
// Backpressure: drives random/patterned rdy and checks address order, hold and completion.
module tb_cnn_layer_accel_weight_seq_engine;

    localparam int NS = 4;
    localparam int SD = 8;

    logic       clk;
    logic       rst;
    logic       cfg_wr_en;
    logic [1:0] cfg_wr_seq;
    logic [2:0] cfg_wr_idx;
    logic [3:0] cfg_wr_data;
    logic       cfg_len_wr_en;
    logic [3:0] cfg_len;
    logic       start;
    logic [1:0] seq_sel;
    logic       loop_en;
    logic       stop;
    logic       wht_addr_rdy;
    logic       wht_addr_vld;
    logic [3:0] wht_addr;
    logic       wht_addr_last;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    // Reference model: plain list of addresses per sequence plus its length.
    int m_tbl [NS][SD];
    int m_len [NS];

    cnn_layer_accel_weight_seq_engine dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_seq(cfg_wr_seq), .cfg_wr_idx(cfg_wr_idx),
        .cfg_wr_data(cfg_wr_data), .cfg_len_wr_en(cfg_len_wr_en), .cfg_len(cfg_len),
        .start(start), .seq_sel(seq_sel), .loop_en(loop_en), .stop(stop),
        .wht_addr_rdy(wht_addr_rdy), .wht_addr_vld(wht_addr_vld), .wht_addr(wht_addr),
        .wht_addr_last(wht_addr_last), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_len[s] = SD;
            for (int i = 0; i < SD; i++) m_tbl[s][i] = 0;
        end
    endtask

    task automatic wr_entry(input int s, input int i, input int d);
        cfg_wr_en = 1'b1; cfg_wr_seq = 2'(s); cfg_wr_idx = 3'(i); cfg_wr_data = 4'(d);
        tick();
        cfg_wr_en = 1'b0;
        m_tbl[s][i] = d;
        chk("wr_no_err", int'(cfg_err), 0);
    endtask

    task automatic wr_len(input int s, input int l);
        bit ok;
        ok = (l >= 1) && (l <= SD);
        cfg_len_wr_en = 1'b1; cfg_wr_seq = 2'(s); cfg_len = 4'(l);
        tick();
        cfg_len_wr_en = 1'b0;
        if (ok) m_len[s] = l;
        chk("len_err", int'(cfg_err), ok ? 0 : 1);
        tick();
        chk("len_err_clear", int'(cfg_err), 0);
    endtask

    // Runs sequence s; rdy_pct<0 selects the 1,0,0 repeating ready pattern.
    task automatic do_run(input int s, input bit lp, input int rdy_pct,
                          input int stop_after, input int rst_after, input bit with_cfg);
        int k;
        int cyc;
        int len;
        bit r;
        k = 0; cyc = 0; len = m_len[s];
        seq_sel = 2'(s); loop_en = lp; start = 1'b1;
        if (with_cfg) begin
            cfg_wr_en = 1'b1; cfg_wr_seq = 2'(s); cfg_wr_idx = 3'd0;
            cfg_wr_data = 4'(15 - m_tbl[s][0]);
        end
        tick();
        start = 1'b0; cfg_wr_en = 1'b0;
        chk("busy_on_start", int'(busy), 1);
        chk("err_on_start", int'(cfg_err), with_cfg ? 1 : 0);
        forever begin
            if (cyc > 300) begin
                chk("run_timeout", cyc, 0);
                stop = 1'b1; tick(); stop = 1'b0;
                return;
            end
            chk("vld", int'(wht_addr_vld), 1);
            chk("addr", int'(wht_addr), m_tbl[s][k % len]);
            chk("last", int'(wht_addr_last), ((k % len) == len - 1) ? 1 : 0);
            if (rst_after >= 0 && k == rst_after) begin
                rst = 1'b1; wht_addr_rdy = 1'b1;
                tick();
                rst = 1'b0;
                model_reset();
                chk("rst_vld", int'(wht_addr_vld), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                return;
            end
            if (stop_after >= 0 && k == stop_after) begin
                stop = 1'b1; wht_addr_rdy = 1'b1;
                tick();
                stop = 1'b0;
                chk("stop_vld", int'(wht_addr_vld), 0);
                chk("stop_done", int'(done), 0);
                chk("stop_busy", int'(busy), 0);
                return;
            end
            r = (rdy_pct < 0) ? (cyc % 3 == 0) : (int'($urandom_range(99)) < rdy_pct);
            wht_addr_rdy = r;
            tick();
            cyc++;
            if (r) begin
                k++;
                if (!lp && k == len) begin
                    wht_addr_rdy = 1'b0;
                    chk("end_vld", int'(wht_addr_vld), 0);
                    chk("end_done", int'(done), 1);
                    chk("end_busy", int'(busy), 0);
                    chk("end_err", int'(cfg_err), 0);
                    tick();
                    chk("done_pulse", int'(done), 0);
                    return;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_seq = '0; cfg_wr_idx = '0; cfg_wr_data = '0;
        cfg_len_wr_en = 1'b0; cfg_len = '0; start = 1'b0; seq_sel = '0; loop_en = 1'b0;
        stop = 1'b0; wht_addr_rdy = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        chk("reset_vld", int'(wht_addr_vld), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(cfg_err), 0);
        chk("reset_addr", int'(wht_addr), 0);
        chk("reset_last", int'(wht_addr_last), 0);

        // T1: default table, full length
        do_run(0, 1'b0, 100, -1, -1, 1'b0);

        // T2: explicit five-entry sequence
        wr_entry(1, 0, 1); wr_entry(1, 1, 9); wr_entry(1, 2, 3);
        wr_entry(1, 3, 4); wr_entry(1, 4, 5);
        wr_len(1, 5);
        do_run(1, 1'b0, 100, -1, -1, 1'b0);

        // T3: patterned backpressure
        do_run(1, 1'b0, -1, -1, -1, 1'b0);

        // T4: looping two-entry sequence stopped after five beats
        wr_entry(2, 0, 6); wr_entry(2, 1, 7);
        wr_len(2, 2);
        do_run(2, 1'b1, 100, 5, -1, 1'b0);

        // T5: rejected commands
        wr_len(0, 0);
        wr_len(0, 9);
        seq_sel = 2'd1; loop_en = 1'b0; start = 1'b1; wht_addr_rdy = 1'b0;
        tick();
        start = 1'b0;
        cfg_wr_en = 1'b1; cfg_wr_seq = 2'd1; cfg_wr_idx = 3'd0; cfg_wr_data = 4'd15;
        tick();
        cfg_wr_en = 1'b0;
        chk("run_wr_err", int'(cfg_err), 1);
        chk("run_wr_busy", int'(busy), 1);
        chk("run_wr_hold", int'(wht_addr), m_tbl[1][0]);
        cfg_len_wr_en = 1'b1; cfg_len = 4'd1;
        tick();
        cfg_len_wr_en = 1'b0;
        chk("run_len_err", int'(cfg_err), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_start_err", int'(cfg_err), 1);
        chk("run_start_busy", int'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stop_busy", int'(busy), 0);
        chk("t5_stop_done", int'(done), 0);
        do_run(1, 1'b0, 100, -1, -1, 1'b0);
        do_run(1, 1'b0, 100, -1, -1, 1'b1);

        // T6: reset mid-run, then everything reads back as cleared
        do_run(1, 1'b0, 100, -1, 3, 1'b0);
        for (int s = 0; s < NS; s++) do_run(s, 1'b0, 100, -1, -1, 1'b0);

        // Randomized configuration and runs
        for (int it = 0; it < 30; it++) begin
            int s;
            int nw;
            bit lp;
            int sa;
            s = int'($urandom_range(NS - 1));
            nw = int'($urandom_range(4));
            for (int w = 0; w < nw; w++)
                wr_entry(s, int'($urandom_range(SD - 1)), int'($urandom_range(15)));
            if ($urandom_range(2) == 0) wr_len(s, int'($urandom_range(9)));
            lp = 1'($urandom_range(1));
            if (lp) sa = int'($urandom_range(1, 20));
            else if ($urandom_range(3) == 0) sa = int'($urandom_range(m_len[s] - 1));
            else sa = -1;
            do_run(s, lp, int'($urandom_range(20, 100)), sa, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
